// File: rtl/masked_sbox_pkg.sv
// Shared constants for the masked S-box lookup sequencer: FSM encoding,
// lookup-table page selectors and BRAM read latency.
package masked_sbox_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    ISSUE1 = 3'd2,
    WAIT0  = 3'd3,
    WAIT1  = 3'd4,
    DONE   = 3'd5
  } sbox_state_e;

  // Table pages: share0/share1 contribution for output share 0 and share 1
  localparam logic [1:0] PG_A0 = 2'b00;
  localparam logic [1:0] PG_B0 = 2'b01;
  localparam logic [1:0] PG_A1 = 2'b10;
  localparam logic [1:0] PG_B1 = 2'b11;

  localparam int BRAM_LAT = 2;

endpackage

// File: rtl/masked_sbox_lut_seq.sv
// Two-share masked S-box via an external dual-port lookup BRAM: issues two
// address pairs, captures the registered read data and refreshes with r.
module masked_sbox_lut_seq #(
  parameter int BRAM_LAT = masked_sbox_pkg::BRAM_LAT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_s0,
  input  logic [7:0] in_s1,
  input  logic [7:0] in_r,
  output logic [9:0] bram_addra,
  output logic [9:0] bram_addrb,
  output logic       bram_en,
  output logic       bram_rst,
  input  logic [7:0] bram_doa,
  input  logic [7:0] bram_dob,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_s0,
  output logic [7:0] out_s1
);
  import masked_sbox_pkg::*;

  // The WAIT0/WAIT1 capture points are fixed to a two-cycle BRAM pipeline
  if (BRAM_LAT != 2) begin : g_lat_chk
    $error("masked_sbox_lut_seq supports BRAM_LAT == 2 only");
  end

  sbox_state_e r_state, w_nxt;

  logic [7:0] r_s0, r_s1, r_r;
  logic [7:0] r_a0, r_b0;
  logic [7:0] r_out_s0, r_out_s1;
  logic       r_out_valid;
  logic       r_bram_rst;
  logic [9:0] w_addra, w_addrb;
  logic       w_en;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_addra = 10'h000;
    w_addrb = 10'h000;
    w_en    = 1'b0;
    case (r_state)
      IDLE:   if (in_valid) w_nxt = ISSUE0;
      ISSUE0: begin
        w_nxt   = ISSUE1;
        w_en    = 1'b1;
        w_addra = {PG_A0, r_s0};
        w_addrb = {PG_B0, r_s1};
      end
      ISSUE1: begin
        w_nxt   = WAIT0;
        w_en    = 1'b1;
        w_addra = {PG_A1, r_s0};
        w_addrb = {PG_B1, r_s1};
      end
      WAIT0:  begin w_nxt = WAIT1; w_en = 1'b1; end
      WAIT1:  begin w_nxt = DONE;  w_en = 1'b1; end
      DONE:   if (out_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Shares only meet inside the output registers; A1/B1 are captured
  // directly into the share-1 XOR so out_valid lands at accept+5.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s0        <= '0;
      r_s1        <= '0;
      r_r         <= '0;
      r_a0        <= '0;
      r_b0        <= '0;
      r_out_s0    <= '0;
      r_out_s1    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_s0 <= in_s0;
          r_s1 <= in_s1;
          r_r  <= in_r;
        end
        WAIT0: begin
          r_a0 <= bram_doa;
          r_b0 <= bram_dob;
        end
        WAIT1: begin
          r_out_s0    <= r_a0 ^ r_b0 ^ r_r;
          r_out_s1    <= bram_doa ^ bram_dob ^ r_r;
          r_out_valid <= 1'b1;
        end
        DONE: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) r_bram_rst <= ~rst;

  assign in_ready   = (r_state == IDLE);
  assign bram_addra = w_addra;
  assign bram_addrb = w_addrb;
  assign bram_en    = w_en;
  assign bram_rst   = r_bram_rst;
  assign out_valid  = r_out_valid;
  assign out_s0     = r_out_s0;
  assign out_s1     = r_out_s1;

endmodule

// File: tb/tb_masked_sbox_lut_seq.sv
// Directed + random bench for masked_sbox_lut_seq with a 2-cycle BRAM model
// and an arithmetic reference of the table contents.
module tb_masked_sbox_lut_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_s0 = '0, in_s1 = '0, in_r = '0;
  logic [9:0] bram_addra, bram_addrb;
  logic       bram_en, bram_rst;
  logic [7:0] bram_doa, bram_dob;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_s0, out_s1;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = 0;

  masked_sbox_lut_seq #(.BRAM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s0(in_s0), .in_s1(in_s1), .in_r(in_r),
    .bram_addra(bram_addra), .bram_addrb(bram_addrb),
    .bram_en(bram_en), .bram_rst(bram_rst),
    .bram_doa(bram_doa), .bram_dob(bram_dob),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s0(out_s0), .out_s1(out_s1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] lut(input logic [9:0] a);
    logic [7:0] pg;
    pg = 8'(a[9:8]);
    return a[7:0] ^ (pg * 8'h11);
  endfunction

  // Two-stage BRAM: address latch then output register, both gated by en
  logic [7:0] d1a = '0, d1b = '0;
  logic [7:0] doa_q = '0, dob_q = '0;
  always @(posedge clk) begin
    if (bram_en) begin
      d1a <= lut(bram_addra);
      d1b <= lut(bram_addrb);
    end
    if (bram_rst) begin
      doa_q <= '0;
      dob_q <= '0;
    end else if (bram_en) begin
      doa_q <= d1a;
      dob_q <= d1b;
    end
  end
  assign bram_doa = doa_q;
  assign bram_dob = dob_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] r,
                    input int hold, input bit rdy_busy, input bit chk_ii,
                    output logic [7:0] o0, output logic [7:0] o1);
    logic [7:0] e0, e1;
    int k;
    e0 = lut({2'b00, s0}) ^ lut({2'b01, s1}) ^ r;
    e1 = lut({2'b10, s0}) ^ lut({2'b11, s1}) ^ r;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("accept_ready", in_ready, 1);
    if (chk_ii) chk("init_interval", cyc - last_acc, 6);
    last_acc = cyc;
    in_valid = 1'b1; in_s0 = s0; in_s1 = s1; in_r = r;
    out_ready = rdy_busy;
    @(negedge clk);
    in_valid = 1'($urandom); in_s0 = 8'($urandom); in_s1 = 8'($urandom); in_r = 8'($urandom);
    chk("t1_addra", bram_addra, {2'b00, s0});
    chk("t1_addrb", bram_addrb, {2'b01, s1});
    chk("t1_en", bram_en, 1);
    chk("t1_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'($urandom);
    chk("t2_addra", bram_addra, {2'b10, s0});
    chk("t2_addrb", bram_addrb, {2'b11, s1});
    chk("t2_en", bram_en, 1);
    @(negedge clk);
    chk("t3_addr", {bram_addra, bram_addrb}, 0);
    chk("t3_en", bram_en, 1);
    @(negedge clk);
    chk("t4_en", bram_en, 1);
    chk("t4_out_valid", out_valid, 0);
    @(negedge clk);
    in_valid = (hold == 0) ? 1'b0 : 1'($urandom);
    out_ready = (hold == 0) ? 1'b1 : 1'b0;
    chk("t5_out_valid", out_valid, 1);
    chk("t5_out_s0", out_s0, e0);
    chk("t5_out_s1", out_s1, e1);
    chk("t5_en", bram_en, 0);
    o0 = out_s0; o1 = out_s1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_shares", {out_s0, out_s1}, {e0, e1});
      chk("hold_in_ready", in_ready, 0);
      in_valid  = (i == hold - 1) ? 1'b0 : 1'($urandom);
      out_ready = (i == hold - 1);
    end
    @(negedge clk);
    out_ready = rdy_busy;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [7:0] a0, a1, b0, b1, rs0, rs1, rr;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_shares", {out_s0, out_s1}, 0);
    chk("rst_addr", {bram_addra, bram_addrb}, 0);
    chk("rst_en", bram_en, 0);
    chk("rst_bram_rst", bram_rst, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_bram_rst", bram_rst, 0);

    // basic lookup with address/enable timing
    op(8'h3C, 8'hA5, 8'h0F, 0, 1'b0, 1'b0, a0, a1);
    chk("basic_s0", a0, 8'h87);
    chk("basic_s1", a1, 8'h87);

    // backpressure for 10 cycles, out_ready toggling while busy
    op(8'h5A, 8'hC3, 8'h21, 10, 1'b1, 1'b0, a0, a1);
    out_ready = 1'b0;

    // mask independence
    op(8'h3C, 8'hA5, 8'h00, 0, 1'b0, 1'b0, a0, a1);
    op(8'h3C, 8'hA5, 8'hFF, 0, 1'b0, 1'b0, b0, b1);
    chk("mask_unmasked_r00", a0 ^ a1, 8'h00);
    chk("mask_unmasked_rFF", b0 ^ b1, 8'h00);
    chk("mask_share_diff", {a0 ^ b0, a1 ^ b1}, 16'hFFFF);

    // reset in the middle of a lookup
    @(negedge clk);
    in_valid = 1'b1; in_s0 = 8'h11; in_s1 = 8'h22; in_r = 8'h33;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_en", bram_en, 0);
    chk("midrst_addr", {bram_addra, bram_addrb}, 0);
    chk("midrst_in_ready", in_ready, 1);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", {out_valid, out_s0, out_s1}, 0);
    end

    // back-to-back random lookups, out_ready held high
    for (int i = 0; i < 8; i++) begin
      rs0 = 8'($urandom); rs1 = 8'($urandom); rr = 8'($urandom);
      op(rs0, rs1, rr, 0, 1'b1, (i > 0), a0, a1);
      chk("b2b_unmasked", a0 ^ a1,
          lut({2'b00, rs0}) ^ lut({2'b01, rs1}) ^ lut({2'b10, rs0}) ^ lut({2'b11, rs1}));
    end
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
